// File: rtl/canny_frame_sequencer_if.sv
// Sequencer bus: start/stall control, frame-buffer read port, pixel stream and result counting.
// master = sequencer side, slave = frame buffer / pipeline / controller side.
interface canny_frame_sequencer_if #(
  parameter int ADDR_W = 18
);
  logic              start;
  logic              stall;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        pixel_out;
  logic              pixel_out_valid;
  logic              result_valid;
  logic [19:0]       out_count;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;

  modport master (
    input  start, stall, mem_rd_data, result_valid,
    output mem_rd_en, mem_addr, pixel_out, pixel_out_valid,
           out_count, busy, frame_done, timeout_err
  );

  modport slave (
    output start, stall, mem_rd_data, result_valid,
    input  mem_rd_en, mem_addr, pixel_out, pixel_out_valid,
           out_count, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/canny_frame_sequencer.sv
// Streams one frame from a sync-read frame buffer into the Canny pipeline and counts result strobes.
// Optional drain watchdog enabled by defining FRAME_SEQ_TIMEOUT_EN.
module canny_frame_sequencer #(
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int ADDR_W  = 18,
  parameter int EXP_OUT = (IMG_W - 4) * (IMG_H - 4),
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  canny_frame_sequencer_if.master  bus
);
  localparam int                NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [19:0]       EXP_CNT   = 20'(EXP_OUT);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [19:0]       out_count;
  logic              rd_vld;
  logic              rd_issue;
  logic              cnt_full;
  logic              count_en;
  logic              wdog_expire;
  logic              timeout_err;

  assign rd_issue = (state == FEED) && !bus.stall;
  assign cnt_full = (out_count == EXP_CNT);
  assign count_en = bus.result_valid && !cnt_full && ((state == FEED) || (state == DRAIN));

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog;

  // wdog holds the number of DRAIN cycles elapsed including the current one
  assign wdog_expire = (state == DRAIN) && !cnt_full && !bus.result_valid &&
                       (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state != DRAIN) || bus.result_valid) wdog <= WD_W'(1);
      else if (!wdog_expire)                    wdog <= wdog + 1'b1;

      if ((state == IDLE) && bus.start) timeout_err <= 1'b0;
      else if (wdog_expire)             timeout_err <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    bus.mem_rd_en       = 1'b0;
    bus.mem_addr        = '0;
    bus.busy            = 1'b1;
    bus.frame_done      = 1'b0;
    bus.pixel_out_valid = rd_vld;
    bus.pixel_out       = rd_vld ? bus.mem_rd_data : 8'h00;
    bus.out_count       = out_count;
    bus.timeout_err     = timeout_err;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = FEED;
      end
      FEED: begin
        bus.mem_rd_en = rd_issue;
        bus.mem_addr  = rd_addr;
        if (rd_issue && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt_full || wdog_expire) state_nxt = DONE;
      end
      DONE: begin
        bus.frame_done = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A read issued last cycle is always delivered; only reset drops it
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      out_count <= '0;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      if (state == IDLE) begin
        rd_addr   <= '0;
        out_count <= '0;
      end else begin
        if (rd_issue) rd_addr   <= rd_addr + 1'b1;
        if (count_en) out_count <= out_count + 20'd1;
      end
    end
  end

endmodule
